vx_perf_memsys_collector: RTL and testbench
===========================================

Name: vx_perf_memsys_collector

Overview:
Producer end of the memory-system performance interface. Counts per-cycle event strobes from icache, dcache, shared memory and the external memory port. Drives all fifteen counters on the interface's master modport for the CSR unit, which is the consumer. Sits in the core/cluster memory subsystem next to the caches.

Parameters:
NUM_REQS, 4, dcache/smem request lanes per cycle
NUM_BANKS, 4, dcache bank count
MAX_PENDING, 64, maximum outstanding external memory reads tracked
CTR_BITS, `PERF_CTR_BITS, counter width (44 by default)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
clear  in  1  synchronous counter clear
icache_rd_fire  in  1  icache read accepted
icache_rd_miss  in  1  icache read miss
dcache_rd_fire  in  NUM_REQS  per-lane dcache read accepted
dcache_wr_fire  in  NUM_REQS  per-lane dcache write accepted
dcache_rd_miss  in  NUM_BANKS  per-bank read miss
dcache_wr_miss  in  NUM_BANKS  per-bank write miss
dcache_bank_stall  in  NUM_BANKS  per-bank conflict stall
dcache_mshr_stall  in  NUM_BANKS  per-bank MSHR-full stall
dup_req  in  NUM_REQS  per-lane merged duplicate request
smem_rd_fire  in  NUM_REQS  per-lane smem read
smem_wr_fire  in  NUM_REQS  per-lane smem write
smem_bank_stall  in  NUM_REQS  per-lane smem bank stall
mem_req_fire  in  1  external memory request accepted
mem_req_rw  in  1  1=write, 0=read; qualified by mem_req_fire
mem_rsp_fire  in  1  external read response accepted
perf_memsys_if  master modport  -  drives icache_reads … dup_reqs

Behaviour:
- Reset (reset_n=0 at a clk edge): all 15 outputs = 0, outstanding = 0. Reset has priority over clear and over events. A reset asserted mid-operation discards in-flight outstanding state.
- clear=1: same effect as reset on counters and outstanding. Events in that cycle are dropped.
- Counters are registered. An event at edge N is visible on the outputs after edge N+1. There is no combinational input-to-output path.
- Each vector input is popcounted per cycle, and the popcount is added to its counter: dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses, dcache_bank_stalls, dcache_mshr_stalls, dup_reqs, smem_reads, smem_writes, smem_bank_stalls. The increment per cycle is 0…NUM_REQS or 0…NUM_BANKS.
- icache_reads += icache_rd_fire; icache_read_misses += icache_rd_miss.
- mem_reads += mem_req_fire & ~mem_req_rw; mem_writes += mem_req_fire & mem_req_rw.
- Outstanding tracker, width $clog2(MAX_PENDING+1):
  - +1 on read request fire; -1 on mem_rsp_fire.
  - Both in the same cycle: unchanged.
  - Response with outstanding = 0: ignored, no underflow; a simulation assertion fires.
  - Read request with outstanding = MAX_PENDING: saturates; assertion fires.
- mem_latency += outstanding (pre-update value) every cycle. This accumulates read-cycles; average latency = mem_latency / mem_reads.
- Arithmetic: unsigned, zero-extended to CTR_BITS. On overflow a counter wraps modulo 2^CTR_BITS, and each counter wraps independently.

Optional Feature:
Macro PERF_MEMSYS_SATURATE_EN.
- Defined: every counter, mem_latency included, saturates at 2^CTR_BITS-1 and holds there until clear/reset.
- Undefined: counters wrap modulo 2^CTR_BITS, as above.

Test Plan:
- Reset/latency: hold reset_n=0 for 3 cycles with all events=1 -> all outputs 0. Release, then pulse icache_rd_fire once -> icache_reads=1 exactly one cycle after the event edge.
- Popcount: dcache_rd_fire=4'b1011 for 5 cycles -> dcache_reads=15. Add dcache_bank_stall=4'b1111 for 2 cycles -> dcache_bank_stalls=8.
- Latency: 2 read requests in consecutive cycles, responses 10 and 12 cycles after the respective request -> mem_reads=2, mem_latency=22. A write request in between -> mem_writes=1, mem_latency unchanged.
- Simultaneous req/rsp with outstanding=1 -> outstanding stays 1. Lone response with outstanding=0 -> outstanding stays 0, assertion logged, mem_latency unaffected.
- Clear: after counts accumulate, clear=1 with smem_wr_fire=4'b1111 in the same cycle -> all counters 0 next cycle, that event not counted.
- Overflow: CTR_BITS=4, 17 icache_rd_fire pulses -> icache_reads=1 without the macro, 15 with PERF_MEMSYS_SATURATE_EN.

Source files
------------

// File: rtl/vx_perf_memsys_collector_if.sv
// ----------------------------------------------------------------------------
// vx_perf_memsys_if
// Memory-system performance counter bundle shared between the collector
// (producer, master modport) and the CSR unit (consumer, slave modport).
//
// Parameters:
//   CTR_BITS : width of every counter, defaults to `PERF_CTR_BITS (44).
//
// Signals (all CTR_BITS wide, driven by the master):
//   icache_reads, icache_read_misses,
//   dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
//   dcache_bank_stalls, dcache_mshr_stalls, dup_reqs,
//   smem_reads, smem_writes, smem_bank_stalls,
//   mem_reads, mem_writes, mem_latency
// ----------------------------------------------------------------------------
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

interface vx_perf_memsys_if #(
  parameter int CTR_BITS = `PERF_CTR_BITS
) ();
  logic [CTR_BITS-1:0] icache_reads;
  logic [CTR_BITS-1:0] icache_read_misses;
  logic [CTR_BITS-1:0] dcache_reads;
  logic [CTR_BITS-1:0] dcache_writes;
  logic [CTR_BITS-1:0] dcache_read_misses;
  logic [CTR_BITS-1:0] dcache_write_misses;
  logic [CTR_BITS-1:0] dcache_bank_stalls;
  logic [CTR_BITS-1:0] dcache_mshr_stalls;
  logic [CTR_BITS-1:0] dup_reqs;
  logic [CTR_BITS-1:0] smem_reads;
  logic [CTR_BITS-1:0] smem_writes;
  logic [CTR_BITS-1:0] smem_bank_stalls;
  logic [CTR_BITS-1:0] mem_reads;
  logic [CTR_BITS-1:0] mem_writes;
  logic [CTR_BITS-1:0] mem_latency;

  modport master (
    output icache_reads, icache_read_misses,
    output dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
    output dcache_bank_stalls, dcache_mshr_stalls, dup_reqs,
    output smem_reads, smem_writes, smem_bank_stalls,
    output mem_reads, mem_writes, mem_latency
  );

  modport slave (
    input icache_reads, icache_read_misses,
    input dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
    input dcache_bank_stalls, dcache_mshr_stalls, dup_reqs,
    input smem_reads, smem_writes, smem_bank_stalls,
    input mem_reads, mem_writes, mem_latency
  );
endinterface

// File: rtl/vx_perf_memsys_collector.sv
// ----------------------------------------------------------------------------
// vx_perf_memsys_collector
// Accumulates per-cycle memory-system event strobes (icache, dcache, shared
// memory, external memory port) into fifteen registered counters presented
// on the master modport of vx_perf_memsys_if.
//
// Optional feature macro: PERF_MEMSYS_SATURATE_EN
//   defined   -> every counter saturates at all-ones until clear/reset
//   undefined -> every counter wraps modulo 2^CTR_BITS
//
// Ports:
//   clk, reset_n (sync, active low), clear (sync counter clear)
//   icache_rd_fire, icache_rd_miss          : 1-bit icache strobes
//   dcache_rd_fire, dcache_wr_fire, dup_req : NUM_REQS per-lane strobes
//   dcache_rd_miss, dcache_wr_miss,
//   dcache_bank_stall, dcache_mshr_stall    : NUM_BANKS per-bank strobes
//   smem_rd_fire, smem_wr_fire,
//   smem_bank_stall                         : NUM_REQS per-lane strobes
//   mem_req_fire, mem_req_rw, mem_rsp_fire  : external memory port
//   perf_memsys_if                          : counter outputs (master)
//
// mem_latency adds the number of outstanding external reads every cycle, so
// mem_latency / mem_reads is the average read latency. Keep CTR_BITS wider
// than $clog2(MAX_PENDING+1) so the per-cycle latency increment fits.
// ----------------------------------------------------------------------------
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_perf_memsys_collector_chk #(
  parameter int MAX_PENDING = 64,
  parameter int OUT_W       = 7
) (
  input logic             clk,
  input logic             reset_n,
  input logic             clear,
  input logic             rd_req,
  input logic             rsp,
  input logic [OUT_W-1:0] outstanding
);
  // Flags tracker misuse: responses with nothing pending, reads beyond capacity.
  always @(posedge clk) begin
    if (reset_n && !clear) begin
      assert (!(rsp && !rd_req && (outstanding == '0)))
        else $warning("perf_memsys: read response with no outstanding read, ignored");
      assert (!(rd_req && !rsp && (outstanding == OUT_W'(MAX_PENDING))))
        else $warning("perf_memsys: outstanding reads at capacity, request not tracked");
    end
  end
endmodule

module vx_perf_memsys_collector #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_BANKS   = 4,
  parameter int MAX_PENDING = 64,
  parameter int CTR_BITS    = `PERF_CTR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 icache_rd_fire,
  input  logic                 icache_rd_miss,
  input  logic [NUM_REQS-1:0]  dcache_rd_fire,
  input  logic [NUM_REQS-1:0]  dcache_wr_fire,
  input  logic [NUM_BANKS-1:0] dcache_rd_miss,
  input  logic [NUM_BANKS-1:0] dcache_wr_miss,
  input  logic [NUM_BANKS-1:0] dcache_bank_stall,
  input  logic [NUM_BANKS-1:0] dcache_mshr_stall,
  input  logic [NUM_REQS-1:0]  dup_req,
  input  logic [NUM_REQS-1:0]  smem_rd_fire,
  input  logic [NUM_REQS-1:0]  smem_wr_fire,
  input  logic [NUM_REQS-1:0]  smem_bank_stall,
  input  logic                 mem_req_fire,
  input  logic                 mem_req_rw,
  input  logic                 mem_rsp_fire,
  vx_perf_memsys_if.master     perf_memsys_if
);
  localparam int OUT_W    = $clog2(MAX_PENDING + 1);
  localparam int NUM_CTRS = 15;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_PENDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  localparam int C_ICACHE_RD    = 0;
  localparam int C_ICACHE_MISS  = 1;
  localparam int C_DCACHE_RD    = 2;
  localparam int C_DCACHE_WR    = 3;
  localparam int C_DCACHE_RMISS = 4;
  localparam int C_DCACHE_WMISS = 5;
  localparam int C_DCACHE_BANK  = 6;
  localparam int C_DCACHE_MSHR  = 7;
  localparam int C_DUP          = 8;
  localparam int C_SMEM_RD      = 9;
  localparam int C_SMEM_WR      = 10;
  localparam int C_SMEM_BANK    = 11;
  localparam int C_MEM_RD       = 12;
  localparam int C_MEM_WR       = 13;
  localparam int C_MEM_LAT      = 14;

  typedef logic [CTR_BITS-1:0] ctr_t;

  function automatic ctr_t popcnt_req(input logic [NUM_REQS-1:0] v);
    ctr_t n;
    n = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      n = n + ctr_t'(v[i]);
    end
    return n;
  endfunction

  function automatic ctr_t popcnt_bank(input logic [NUM_BANKS-1:0] v);
    ctr_t n;
    n = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      n = n + ctr_t'(v[i]);
    end
    return n;
  endfunction

  function automatic ctr_t ctr_add(input ctr_t a, input ctr_t b);
`ifdef PERF_MEMSYS_SATURATE_EN
    logic [CTR_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CTR_BITS] ? {CTR_BITS{1'b1}} : sum[CTR_BITS-1:0];
`else
    return a + b;
`endif
  endfunction

  ctr_t             ctr_r     [NUM_CTRS];
  ctr_t             inc_s     [NUM_CTRS];
  ctr_t             ctr_nxt_s [NUM_CTRS];
  logic [OUT_W-1:0] outstanding_r;
  logic [OUT_W-1:0] outstanding_nxt_s;
  logic             rd_req_s;
  logic             wr_req_s;

  assign rd_req_s = mem_req_fire & ~mem_req_rw;
  assign wr_req_s = mem_req_fire &  mem_req_rw;

  // Per-cycle increment of every counter and the resulting next value.
  always_comb begin
    inc_s[C_ICACHE_RD]    = ctr_t'(icache_rd_fire);
    inc_s[C_ICACHE_MISS]  = ctr_t'(icache_rd_miss);
    inc_s[C_DCACHE_RD]    = popcnt_req(dcache_rd_fire);
    inc_s[C_DCACHE_WR]    = popcnt_req(dcache_wr_fire);
    inc_s[C_DCACHE_RMISS] = popcnt_bank(dcache_rd_miss);
    inc_s[C_DCACHE_WMISS] = popcnt_bank(dcache_wr_miss);
    inc_s[C_DCACHE_BANK]  = popcnt_bank(dcache_bank_stall);
    inc_s[C_DCACHE_MSHR]  = popcnt_bank(dcache_mshr_stall);
    inc_s[C_DUP]          = popcnt_req(dup_req);
    inc_s[C_SMEM_RD]      = popcnt_req(smem_rd_fire);
    inc_s[C_SMEM_WR]      = popcnt_req(smem_wr_fire);
    inc_s[C_SMEM_BANK]    = popcnt_req(smem_bank_stall);
    inc_s[C_MEM_RD]       = ctr_t'(rd_req_s);
    inc_s[C_MEM_WR]       = ctr_t'(wr_req_s);
    // Latency accumulates the pre-update outstanding count.
    inc_s[C_MEM_LAT]      = ctr_t'(outstanding_r);
    for (int i = 0; i < NUM_CTRS; i++) begin
      ctr_nxt_s[i] = ctr_add(ctr_r[i], inc_s[i]);
    end
  end

  // Outstanding read tracker: saturates at MAX_PENDING, never underflows.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({rd_req_s, mem_rsp_fire})
      2'b10: begin
        if (outstanding_r != OUT_MAX) begin
          outstanding_nxt_s = outstanding_r + OUT_ONE;
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      2'b01: begin
        if (outstanding_r != '0) begin
          outstanding_nxt_s = outstanding_r - OUT_ONE;
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Counter and tracker state; reset and clear both drop the cycle's events.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_r[i] <= '0;
      end
      outstanding_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_r[i] <= ctr_nxt_s[i];
      end
      outstanding_r <= outstanding_nxt_s;
    end
  end

  assign perf_memsys_if.icache_reads        = ctr_r[C_ICACHE_RD];
  assign perf_memsys_if.icache_read_misses  = ctr_r[C_ICACHE_MISS];
  assign perf_memsys_if.dcache_reads        = ctr_r[C_DCACHE_RD];
  assign perf_memsys_if.dcache_writes       = ctr_r[C_DCACHE_WR];
  assign perf_memsys_if.dcache_read_misses  = ctr_r[C_DCACHE_RMISS];
  assign perf_memsys_if.dcache_write_misses = ctr_r[C_DCACHE_WMISS];
  assign perf_memsys_if.dcache_bank_stalls  = ctr_r[C_DCACHE_BANK];
  assign perf_memsys_if.dcache_mshr_stalls  = ctr_r[C_DCACHE_MSHR];
  assign perf_memsys_if.dup_reqs            = ctr_r[C_DUP];
  assign perf_memsys_if.smem_reads          = ctr_r[C_SMEM_RD];
  assign perf_memsys_if.smem_writes         = ctr_r[C_SMEM_WR];
  assign perf_memsys_if.smem_bank_stalls    = ctr_r[C_SMEM_BANK];
  assign perf_memsys_if.mem_reads           = ctr_r[C_MEM_RD];
  assign perf_memsys_if.mem_writes          = ctr_r[C_MEM_WR];
  assign perf_memsys_if.mem_latency         = ctr_r[C_MEM_LAT];

  vx_perf_memsys_collector_chk #(
    .MAX_PENDING (MAX_PENDING),
    .OUT_W       (OUT_W)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .rd_req      (rd_req_s),
    .rsp         (mem_rsp_fire),
    .outstanding (outstanding_r)
  );
endmodule

// File: tb/tb_vx_perf_memsys_collector.sv
// ----------------------------------------------------------------------------
// tb_vx_perf_memsys_collector
// Drives a 44-bit collector and a 4-bit collector from the same strobes.
// Expected counter values are queued when a cycle's stimulus is driven and
// compared one clock later, #1 after the rising edge.
// ----------------------------------------------------------------------------
module tb_vx_perf_memsys_collector;
  localparam int NUM_OUT = 15;
  localparam int C_ICR   = 0;
  localparam int C_ICM   = 1;
  localparam int C_MRD   = 12;
  localparam int C_MWR   = 13;
  localparam int C_MLAT  = 14;
  localparam int C_SMALL = 15;
  localparam int NUM_VEC = 10;

`ifdef PERF_MEMSYS_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       icache_rd_fire;
  logic       icache_rd_miss;
  logic [3:0] dcache_rd_fire;
  logic [3:0] dcache_wr_fire;
  logic [3:0] dcache_rd_miss;
  logic [3:0] dcache_wr_miss;
  logic [3:0] dcache_bank_stall;
  logic [3:0] dcache_mshr_stall;
  logic [3:0] dup_req;
  logic [3:0] smem_rd_fire;
  logic [3:0] smem_wr_fire;
  logic [3:0] smem_bank_stall;
  logic       mem_req_fire;
  logic       mem_req_rw;
  logic       mem_rsp_fire;

  vx_perf_memsys_if #(.CTR_BITS(44)) perf_if ();
  vx_perf_memsys_if #(.CTR_BITS(4))  perf_small_if ();

  vx_perf_memsys_collector #(
    .NUM_REQS(4), .NUM_BANKS(4), .MAX_PENDING(64), .CTR_BITS(44)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .icache_rd_fire(icache_rd_fire), .icache_rd_miss(icache_rd_miss),
    .dcache_rd_fire(dcache_rd_fire), .dcache_wr_fire(dcache_wr_fire),
    .dcache_rd_miss(dcache_rd_miss), .dcache_wr_miss(dcache_wr_miss),
    .dcache_bank_stall(dcache_bank_stall), .dcache_mshr_stall(dcache_mshr_stall),
    .dup_req(dup_req), .smem_rd_fire(smem_rd_fire), .smem_wr_fire(smem_wr_fire),
    .smem_bank_stall(smem_bank_stall), .mem_req_fire(mem_req_fire),
    .mem_req_rw(mem_req_rw), .mem_rsp_fire(mem_rsp_fire),
    .perf_memsys_if(perf_if)
  );

  vx_perf_memsys_collector #(
    .NUM_REQS(4), .NUM_BANKS(4), .MAX_PENDING(4), .CTR_BITS(4)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .icache_rd_fire(icache_rd_fire), .icache_rd_miss(icache_rd_miss),
    .dcache_rd_fire(dcache_rd_fire), .dcache_wr_fire(dcache_wr_fire),
    .dcache_rd_miss(dcache_rd_miss), .dcache_wr_miss(dcache_wr_miss),
    .dcache_bank_stall(dcache_bank_stall), .dcache_mshr_stall(dcache_mshr_stall),
    .dup_req(dup_req), .smem_rd_fire(smem_rd_fire), .smem_wr_fire(smem_wr_fire),
    .smem_bank_stall(smem_bank_stall), .mem_req_fire(mem_req_fire),
    .mem_req_rw(mem_req_rw), .mem_rsp_fire(mem_rsp_fire),
    .perf_memsys_if(perf_small_if)
  );

  // Lane j of a vector record drives the strobe whose counter index is 11-j:
  // written left to right as dcache_rd, dcache_wr, rd_miss, wr_miss,
  // bank_stall, mshr_stall, dup, smem_rd, smem_wr, smem_bank_stall.
  typedef struct packed {
    logic [9:0][3:0] in_v;
    logic [9:0][7:0] exp_v;
  } vec_t;

  typedef struct {
    int          idx;
    logic [43:0] val;
  } exp_t;

  vec_t vecs [NUM_VEC];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] get_ctr(input int idx);
    case (idx)
      0:  return perf_if.icache_reads;
      1:  return perf_if.icache_read_misses;
      2:  return perf_if.dcache_reads;
      3:  return perf_if.dcache_writes;
      4:  return perf_if.dcache_read_misses;
      5:  return perf_if.dcache_write_misses;
      6:  return perf_if.dcache_bank_stalls;
      7:  return perf_if.dcache_mshr_stalls;
      8:  return perf_if.dup_reqs;
      9:  return perf_if.smem_reads;
      10: return perf_if.smem_writes;
      11: return perf_if.smem_bank_stalls;
      12: return perf_if.mem_reads;
      13: return perf_if.mem_writes;
      14: return perf_if.mem_latency;
      15: return {40'd0, perf_small_if.icache_reads};
      default: return 44'd0;
    endcase
  endfunction

  function automatic string ctr_name(input int idx);
    case (idx)
      0:  return "icache_reads";
      1:  return "icache_read_misses";
      2:  return "dcache_reads";
      3:  return "dcache_writes";
      4:  return "dcache_read_misses";
      5:  return "dcache_write_misses";
      6:  return "dcache_bank_stalls";
      7:  return "dcache_mshr_stalls";
      8:  return "dup_reqs";
      9:  return "smem_reads";
      10: return "smem_writes";
      11: return "smem_bank_stalls";
      12: return "mem_reads";
      13: return "mem_writes";
      14: return "mem_latency";
      15: return "small_icache_reads";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ctr(input int idx, input logic [43:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic expect_all_zero();
    for (int k = 0; k < NUM_OUT; k++) expect_ctr(k, 44'd0);
  endtask

  // One clock: outputs settle, then every queued expectation is retired.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(ctr_name(e.idx), get_ctr(e.idx), e.val);
    end
  endtask

  task automatic idle_inputs();
    icache_rd_fire = 1'b0; icache_rd_miss = 1'b0;
    dcache_rd_fire = 4'd0; dcache_wr_fire = 4'd0;
    dcache_rd_miss = 4'd0; dcache_wr_miss = 4'd0;
    dcache_bank_stall = 4'd0; dcache_mshr_stall = 4'd0;
    dup_req = 4'd0; smem_rd_fire = 4'd0; smem_wr_fire = 4'd0;
    smem_bank_stall = 4'd0;
    mem_req_fire = 1'b0; mem_req_rw = 1'b0; mem_rsp_fire = 1'b0;
  endtask

  task automatic all_events();
    icache_rd_fire = 1'b1; icache_rd_miss = 1'b1;
    dcache_rd_fire = 4'hF; dcache_wr_fire = 4'hF;
    dcache_rd_miss = 4'hF; dcache_wr_miss = 4'hF;
    dcache_bank_stall = 4'hF; dcache_mshr_stall = 4'hF;
    dup_req = 4'hF; smem_rd_fire = 4'hF; smem_wr_fire = 4'hF;
    smem_bank_stall = 4'hF;
    mem_req_fire = 1'b1; mem_req_rw = 1'b0; mem_rsp_fire = 1'b1;
  endtask

  task automatic drive_lane(input int j, input logic [3:0] v);
    case (j)
      9: dcache_rd_fire    = v;
      8: dcache_wr_fire    = v;
      7: dcache_rd_miss    = v;
      6: dcache_wr_miss    = v;
      5: dcache_bank_stall = v;
      4: dcache_mshr_stall = v;
      3: dup_req           = v;
      2: smem_rd_fire      = v;
      1: smem_wr_fire      = v;
      0: smem_bank_stall   = v;
      default: ;
    endcase
  endtask

  task automatic mem_step(input logic req, input logic rsp, input int lat, input int reads);
    mem_req_fire = req;
    mem_req_rw   = 1'b0;
    mem_rsp_fire = rsp;
    expect_ctr(C_MLAT, 44'(lat));
    expect_ctr(C_MRD, 44'(reads));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cumulative expectations after each vector (counters start from zero).
    vecs[0] = '{in_v: {4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd3,  8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[1] = '{in_v: {4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd6,  8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[2] = '{in_v: {4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd9,  8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[3] = '{in_v: {4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd12, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[4] = '{in_v: {4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd15, 8'd0,  8'd0, 8'd0, 8'd4,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[5] = '{in_v: {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd15, 8'd0,  8'd0, 8'd0, 8'd8,  8'd0, 8'd0, 8'd0,  8'd0, 8'd0}};
    vecs[6] = '{in_v: {4'b0000, 4'b0110, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 4'b1110, 4'b1111, 4'b0010, 4'b1001},
                exp_v: {8'd15, 8'd2,  8'd1, 8'd1, 8'd8,  8'd2, 8'd3, 8'd4,  8'd1, 8'd2}};
    vecs[7] = '{in_v: {4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1100, 4'b0111},
                exp_v: {8'd15, 8'd6,  8'd5, 8'd1, 8'd8,  8'd3, 8'd4, 8'd6,  8'd3, 8'd5}};
    vecs[8] = '{in_v: {4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111},
                exp_v: {8'd19, 8'd10, 8'd9, 8'd5, 8'd12, 8'd7, 8'd8, 8'd10, 8'd7, 8'd9}};
    vecs[9] = '{in_v: {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_v: {8'd19, 8'd10, 8'd9, 8'd5, 8'd12, 8'd7, 8'd8, 8'd10, 8'd7, 8'd9}};

    // Reset held for three cycles with every event asserted.
    clear   = 1'b0;
    reset_n = 1'b0;
    all_events();
    for (int c = 0; c < 3; c++) begin
      expect_all_zero();
      expect_ctr(C_SMALL, 44'd0);
      tick();
    end

    // Release, then a single icache pulse appears one clock later.
    idle_inputs();
    reset_n = 1'b1;
    expect_all_zero();
    tick();
    icache_rd_fire = 1'b1;
    icache_rd_miss = 1'b1;
    #1;
    check("no_comb_path", get_ctr(C_ICR), 44'd0);
    expect_ctr(C_ICR, 44'd1);
    expect_ctr(C_ICM, 44'd1);
    tick();
    idle_inputs();
    expect_ctr(C_ICR, 44'd1);
    expect_ctr(C_ICM, 44'd1);
    tick();

    // Table-driven popcount vectors.
    for (int v = 0; v < NUM_VEC; v++) begin
      for (int j = 0; j < 10; j++) begin
        drive_lane(j, vecs[v].in_v[j]);
        expect_ctr(11 - j, 44'(vecs[v].exp_v[j]));
      end
      tick();
    end
    idle_inputs();

    // Two reads at e0/e1, write at e5, responses at e10 and e13.
    for (int k = 0; k < 15; k++) begin
      mem_req_fire = (k == 0) || (k == 1) || (k == 5);
      mem_req_rw   = (k == 5);
      mem_rsp_fire = (k == 10) || (k == 13);
      if (k == 10) expect_ctr(C_MLAT, 44'd19);
      tick();
    end
    idle_inputs();
    expect_ctr(C_MRD, 44'd2);
    expect_ctr(C_MWR, 44'd1);
    expect_ctr(C_MLAT, 44'd22);
    tick();

    // Simultaneous req/rsp, lone response at zero, no underflow afterwards.
    mem_step(1'b1, 1'b0, 22, 3);
    mem_step(1'b1, 1'b1, 23, 4);
    mem_step(1'b0, 1'b0, 24, 4);
    mem_step(1'b0, 1'b1, 25, 4);
    mem_step(1'b0, 1'b0, 25, 4);
    mem_step(1'b0, 1'b1, 25, 4);
    mem_step(1'b0, 1'b0, 25, 4);
    mem_step(1'b1, 1'b0, 25, 5);
    mem_step(1'b0, 1'b0, 26, 5);

    // Clear with a read still outstanding and events in the clear cycle.
    clear        = 1'b1;
    smem_wr_fire = 4'hF;
    mem_req_fire = 1'b1;
    expect_all_zero();
    expect_ctr(C_SMALL, 44'd0);
    tick();
    clear = 1'b0;
    idle_inputs();
    expect_ctr(10, 44'd0);
    expect_ctr(C_MLAT, 44'd0);
    expect_ctr(C_MRD, 44'd0);
    tick();
    expect_ctr(C_MLAT, 44'd0);
    tick();

    // Seventeen icache pulses into the 4-bit instance.
    for (int p = 0; p < 17; p++) begin
      icache_rd_fire = 1'b1;
      if (p == 14) begin
        expect_ctr(C_SMALL, 44'd15);
        expect_ctr(C_ICR, 44'd15);
      end
      if (p == 15) expect_ctr(C_SMALL, SAT ? 44'd15 : 44'd0);
      tick();
    end
    idle_inputs();
    expect_ctr(C_SMALL, SAT ? 44'd15 : 44'd1);
    expect_ctr(C_ICR, 44'd17);
    tick();

    // Reset in the middle of an outstanding read discards it.
    mem_req_fire = 1'b1;
    expect_ctr(C_MRD, 44'd1);
    tick();
    idle_inputs();
    reset_n = 1'b0;
    expect_all_zero();
    tick();
    reset_n = 1'b1;
    expect_ctr(C_MLAT, 44'd0);
    expect_ctr(C_MRD, 44'd0);
    tick();
    expect_ctr(C_MLAT, 44'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
